// File: rtl/spi_pico_deframer_if.sv
// spi_pico_deframer_if: PICO serial input and framed register-write outputs of the deframer
interface spi_pico_deframer_if;
    logic       serial_in;
    logic [7:0] write_data;
    logic [7:0] mux_control_signal;
    logic       msg_flag;
    logic       frame_active;
    logic       frame_done;
    logic       addr_err;
    modport master (output serial_in, input write_data, mux_control_signal, msg_flag, frame_active, frame_done, addr_err);
    modport slave  (input serial_in, output write_data, mux_control_signal, msg_flag, frame_active, frame_done, addr_err);
endinterface

// File: rtl/spi_pico_deframer.sv
// spi_pico_deframer: ADDR/LEN/DATA PICO deframer with auto-increment; SPI_PICO_ADDR_CHK_EN enables address range check
module spi_pico_deframer #(
    parameter int MIN_ADDR = 1,
    parameter int MAX_ADDR = 65
) (
    input  logic                  sclk,
    input  logic                  rstn,
    spi_pico_deframer_if.slave    bus
);
    typedef enum logic [1:0] {S_ADDR, S_LEN, S_DATA} state_t;
    localparam logic [7:0] MIN_A = 8'(MIN_ADDR);
    localparam logic [7:0] MAX_A = 8'(MAX_ADDR);
    state_t     state;
    logic [7:0] sr;
    logic [2:0] bit_cnt;
    logic [7:0] byte_cnt;
    logic [7:0] cur_addr;
    logic [7:0] byte_in;
    logic       done;
    logic       ok;
    assign byte_in = {sr[6:0], bus.serial_in};
    assign done    = bit_cnt == 3'd7;
`ifdef SPI_PICO_ADDR_CHK_EN
    assign ok = cur_addr >= MIN_A && cur_addr <= MAX_A;
`else
    assign ok = 1'b1;
    assign bus.addr_err = 1'b0;
`endif
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            state                  <= S_ADDR;
            sr                     <= '0;
            bit_cnt                <= '0;
            byte_cnt               <= '0;
            cur_addr               <= '0;
            bus.write_data         <= '0;
            bus.mux_control_signal <= '0;
            bus.msg_flag           <= 1'b0;
            bus.frame_active       <= 1'b0;
            bus.frame_done         <= 1'b0;
`ifdef SPI_PICO_ADDR_CHK_EN
            bus.addr_err           <= 1'b0;
`endif
        end else begin
            sr             <= byte_in;
            bit_cnt        <= bit_cnt + 3'd1;
            bus.msg_flag   <= 1'b0;
            bus.frame_done <= 1'b0;
            if (done) begin
                case (state)
                    S_ADDR: begin
                        cur_addr               <= byte_in;
                        bus.mux_control_signal <= '0;
                        bus.frame_active       <= 1'b1;
                        state                  <= S_LEN;
                    end
                    S_LEN: begin
                        byte_cnt <= byte_in;
                        if (byte_in == 8'd0) begin
                            bus.frame_done   <= 1'b1;
                            bus.frame_active <= 1'b0;
                            state            <= S_ADDR;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (ok) begin
                            bus.write_data         <= byte_in;
                            bus.mux_control_signal <= cur_addr;
                            bus.msg_flag           <= 1'b1;
                        end
`ifdef SPI_PICO_ADDR_CHK_EN
                        else bus.addr_err <= 1'b1;
`endif
                        cur_addr <= (cur_addr == MAX_A) ? MIN_A : cur_addr + 8'd1;
                        byte_cnt <= byte_cnt - 8'd1;
                        if (byte_cnt == 8'd1) begin
                            bus.frame_done   <= 1'b1;
                            bus.frame_active <= 1'b0;
                            state            <= S_ADDR;
                        end
                    end
                    default: state <= S_ADDR;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_pico_deframer.sv
// tb_spi_pico_deframer: directed frame vectors with hand-computed expectations
module tb_spi_pico_deframer;
    logic sclk = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    spi_pico_deframer_if bus ();
    spi_pico_deframer #(.MIN_ADDR(1), .MAX_ADDR(65)) dut (.sclk(sclk), .rstn(rstn), .bus(bus));
    always #5 sclk = ~sclk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // bits are set just after each posedge, so every bit is stable for the next sampling edge
    task automatic send_bits(input logic [7:0] b, input int n);
        for (int k = 0; k < n; k++) begin
            bus.serial_in = b[7-k];
            @(posedge sclk);
            #1;
            if (k < 7) begin
                check("msg_flag_idle", {7'd0, bus.msg_flag}, 8'd0);
                check("frame_done_idle", {7'd0, bus.frame_done}, 8'd0);
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
    endtask

    task automatic expect_out(input string tag, input logic [7:0] wd, input logic [7:0] mux,
                              input logic msg, input logic fd, input logic act);
        check({tag, "_write_data"}, bus.write_data, wd);
        check({tag, "_mux"}, bus.mux_control_signal, mux);
        check({tag, "_msg_flag"}, {7'd0, bus.msg_flag}, {7'd0, msg});
        check({tag, "_frame_done"}, {7'd0, bus.frame_done}, {7'd0, fd});
        check({tag, "_frame_active"}, {7'd0, bus.frame_active}, {7'd0, act});
    endtask

    initial begin
        bus.serial_in = 1'b0;
        #23;
        expect_out("reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        check("reset_addr_err", {7'd0, bus.addr_err}, 8'd0);
        rstn = 1'b1;
        // single-byte frame
        send_byte(8'h02);
        expect_out("t1_addr", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        send_byte(8'h01);
        expect_out("t1_len", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        send_byte(8'h03);
        expect_out("t1_data", 8'h03, 8'h02, 1'b1, 1'b1, 1'b0);
        // three bytes with auto-increment; pulses drop on the next edge inside send_byte
        send_byte(8'd61);
        send_byte(8'd3);
        expect_out("t2_len", 8'h03, 8'h00, 1'b0, 1'b0, 1'b1);
        send_byte(8'hAA);
        expect_out("t2_d0", 8'hAA, 8'd61, 1'b1, 1'b0, 1'b1);
        send_byte(8'hBB);
        expect_out("t2_d1", 8'hBB, 8'd62, 1'b1, 1'b0, 1'b1);
        send_byte(8'hCC);
        expect_out("t2_d2", 8'hCC, 8'd63, 1'b1, 1'b1, 1'b0);
        // wrap MAX_ADDR -> MIN_ADDR
        send_byte(8'd65);
        send_byte(8'd2);
        send_byte(8'h11);
        expect_out("t3_d0", 8'h11, 8'd65, 1'b1, 1'b0, 1'b1);
        send_byte(8'h22);
        expect_out("t3_d1", 8'h22, 8'd1, 1'b1, 1'b1, 1'b0);
        // LEN=0 frame, then a normal frame
        send_byte(8'd3);
        send_byte(8'd0);
        expect_out("t4_len0", 8'h22, 8'h00, 1'b0, 1'b1, 1'b0);
        send_byte(8'd1);
        send_byte(8'd1);
        send_byte(8'h5A);
        expect_out("t4_next", 8'h5A, 8'd1, 1'b1, 1'b1, 1'b0);
        // reset mid data byte
        send_byte(8'd2);
        send_byte(8'd1);
        send_bits(8'hF0, 3);
        #2 rstn = 1'b0;
        #1;
        expect_out("t5_reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge sclk);
        @(negedge sclk);
        rstn = 1'b1;
        send_byte(8'd2);
        send_byte(8'd1);
        send_byte(8'h01);
        expect_out("t5_after", 8'h01, 8'd2, 1'b1, 1'b1, 1'b0);
        // out-of-range target address
        send_byte(8'd70);
        send_byte(8'd1);
        send_byte(8'hFF);
`ifdef SPI_PICO_ADDR_CHK_EN
        expect_out("t6_chk", 8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
        check("t6_addr_err", {7'd0, bus.addr_err}, 8'd1);
        send_byte(8'd2);
        send_byte(8'd1);
        send_byte(8'h77);
        expect_out("t6_sticky", 8'h77, 8'd2, 1'b1, 1'b1, 1'b0);
        check("t6_err_sticky", {7'd0, bus.addr_err}, 8'd1);
`else
        expect_out("t6_nochk", 8'hFF, 8'd70, 1'b1, 1'b1, 1'b0);
        check("t6_addr_err", {7'd0, bus.addr_err}, 8'd0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
